// File: rtl/sort_net_pkg.sv
// Shared types and helpers for the iterative odd-even sorter.
// The index-tag feature is controlled by SORT_NET_INDEX_EN in the top level.
package sort_net_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SORT,
    S_DONE
  } state_t;

  localparam logic PHASE_EVEN = 1'b0;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sort_net_iter_cmp_swap.sv
// Compare-exchange decision for one adjacent key pair.
// Equal keys never swap, which keeps duplicates in input order.
module cmp_swap
  import sort_net_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         desc,
  output logic         swapped
);

  assign swapped = desc ? (a < b) : (a > b);

endmodule

// File: rtl/sort_net_iter.sv
// Iterative odd-even transposition sorter: N unsigned W-bit keys, one phase per clock.
// Define SORT_NET_INDEX_EN to add out_idx, the source slot of each sorted key.
module sort_net_iter
  import sort_net_pkg::*;
#(
  parameter  int N    = 4,
  parameter  int W    = 8,
  localparam int IDXW = clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*W-1:0]  in_data,
  input  logic            desc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*W-1:0]  out_data,
`ifdef SORT_NET_INDEX_EN
  output logic [N*IDXW-1:0] out_idx,
`endif
  output logic            busy
);

  localparam int PW = clog2(N);

  state_t         state;
  state_t         state_nxt;
  logic [PW-1:0]  phase;
  logic           dsc;
  logic [W-1:0]   keys [N];
  logic [W-1:0]   nk   [N];
  logic [N/2-1:0] sw_e;
  logic [N/2-1:0] sw_o;
  logic           last;

`ifdef SORT_NET_INDEX_EN
  logic [IDXW-1:0] tags [N];
  logic [IDXW-1:0] nt   [N];
`endif

  assign last = (phase == PW'(N - 1));

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = S_SORT;
      end
      S_SORT: begin
        if (last) state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  for (genvar g = 0; g < N / 2; g++) begin : g_even
    cmp_swap #(.W(W)) u_cs (
      .a      (keys[2*g]),
      .b      (keys[2*g+1]),
      .desc   (dsc),
      .swapped(sw_e[g])
    );
  end

  for (genvar g = 0; g < N / 2 - 1; g++) begin : g_odd
    cmp_swap #(.W(W)) u_cs (
      .a      (keys[2*g+1]),
      .b      (keys[2*g+2]),
      .desc   (dsc),
      .swapped(sw_o[g])
    );
  end

  // The odd phase has one pair fewer; the top flag pads the vector.
  assign sw_o[N/2-1] = 1'b0;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      nk[i] = keys[i];
`ifdef SORT_NET_INDEX_EN
      nt[i] = tags[i];
`endif
    end
    if (phase[0] == PHASE_EVEN) begin
      for (int g = 0; g < N / 2; g++) begin
        if (sw_e[g]) begin
          nk[2*g]   = keys[2*g+1];
          nk[2*g+1] = keys[2*g];
`ifdef SORT_NET_INDEX_EN
          nt[2*g]   = tags[2*g+1];
          nt[2*g+1] = tags[2*g];
`endif
        end
      end
    end else begin
      for (int g = 0; g < N / 2; g++) begin
        if (sw_o[g]) begin
          nk[2*g+1]       = keys[(2*g+2)%N];
          nk[(2*g+2)%N]   = keys[2*g+1];
`ifdef SORT_NET_INDEX_EN
          nt[2*g+1]       = tags[(2*g+2)%N];
          nt[(2*g+2)%N]   = tags[2*g+1];
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      phase <= '0;
      dsc   <= 1'b0;
      for (int i = 0; i < N; i++) begin
        keys[i] <= '0;
`ifdef SORT_NET_INDEX_EN
        tags[i] <= '0;
`endif
      end
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            phase <= '0;
            dsc   <= desc;
            for (int i = 0; i < N; i++) begin
              keys[i] <= in_data[i*W +: W];
`ifdef SORT_NET_INDEX_EN
              tags[i] <= IDXW'(i);
`endif
            end
          end
        end
        S_SORT: begin
          phase <= phase + 1'b1;
          for (int i = 0; i < N; i++) begin
            keys[i] <= nk[i];
`ifdef SORT_NET_INDEX_EN
            tags[i] <= nt[i];
`endif
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_out
    assign out_data[i*W +: W] = keys[i];
`ifdef SORT_NET_INDEX_EN
    assign out_idx[i*IDXW +: IDXW] = tags[i];
`endif
  end

endmodule

// File: tb/tb_sort_net_iter.sv
// Bench for sort_net_iter: directed N=4 cases plus randomized N=8,W=12 traffic
// against a stable insertion-sort reference model.
module tb_sort_net_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        iv4, ir4, d4, ov4, or4, busy4;
  logic [31:0] id4, od4;
  logic        iv8, ir8, d8, ov8, or8, busy8;
  logic [95:0] id8, od8;
`ifdef SORT_NET_INDEX_EN
  logic [7:0]  ox4;
  logic [23:0] ox8;
`endif

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  sort_net_iter #(.N(4), .W(8)) dut4 (
    .clk(clk), .reset(reset),
    .in_valid(iv4), .in_ready(ir4), .in_data(id4), .desc(d4),
    .out_valid(ov4), .out_ready(or4), .out_data(od4),
`ifdef SORT_NET_INDEX_EN
    .out_idx(ox4),
`endif
    .busy(busy4)
  );

  sort_net_iter #(.N(8), .W(12)) dut8 (
    .clk(clk), .reset(reset),
    .in_valid(iv8), .in_ready(ir8), .in_data(id8), .desc(d8),
    .out_valid(ov8), .out_ready(or8), .out_data(od8),
`ifdef SORT_NET_INDEX_EN
    .out_idx(ox8),
`endif
    .busy(busy8)
  );

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] p4(input int a0, input int a1,
                                     input int a2, input int a3);
    return {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  // Stable insertion sort: strict comparison keeps equal keys in input order.
  function automatic void model(input int n, input int w, input int iw,
                                input int kin[8], input bit d,
                                output logic [127:0] pk,
                                output logic [127:0] px);
    int k[8];
    int x[8];
    int t;
    for (int i = 0; i < 8; i++) begin
      k[i] = kin[i];
      x[i] = i;
    end
    for (int i = 1; i < n; i++) begin
      for (int j = i; j > 0; j--) begin
        if (d ? (k[j] > k[j-1]) : (k[j] < k[j-1])) begin
          t = k[j]; k[j] = k[j-1]; k[j-1] = t;
          t = x[j]; x[j] = x[j-1]; x[j-1] = t;
        end
      end
    end
    pk = '0;
    px = '0;
    for (int i = 0; i < n; i++) begin
      pk |= 128'(k[i]) << (i * w);
      px |= 128'(x[i]) << (i * iw);
    end
  endfunction

  task automatic run4(input string tag, input logic [31:0] din, input bit d,
                      input logic [31:0] exp, input logic [7:0] expx,
                      input int hold);
    int k;
    k = 0;
    while (!ir4 && k < 20) begin
      tick();
      k++;
    end
    chk({tag, "_in_ready"}, 128'(ir4), 128'(1));
    iv4 = 1'b1; id4 = din; d4 = d;
    tick();
    iv4 = 1'b0; d4 = ~d; id4 = '1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk({tag, "_latency"}, 128'(ov4), 128'(c == 4));
    end
    chk({tag, "_data"}, 128'(od4), 128'(exp));
`ifdef SORT_NET_INDEX_EN
    chk({tag, "_idx"}, 128'(ox4), 128'(expx));
`else
    if (expx != expx) chk({tag, "_idx"}, 128'(expx), 128'(0));
`endif
    for (int h = 0; h < hold; h++) begin
      iv4 = 1'b1;
      tick();
      chk({tag, "_hold_valid"}, 128'(ov4), 128'(1));
      chk({tag, "_hold_data"}, 128'(od4), 128'(exp));
      chk({tag, "_hold_ready"}, 128'(ir4), 128'(0));
    end
    iv4 = 1'b0;
    or4 = 1'b1;
    tick();
    or4 = 1'b0;
    chk({tag, "_drop_valid"}, 128'(ov4), 128'(0));
    chk({tag, "_idle_ready"}, 128'(ir4), 128'(1));
    chk({tag, "_idle_busy"}, 128'(busy4), 128'(0));
  endtask

  initial begin
    int kk[8];
    bit dd;
    int k, cyc;
    bit hs, seen, ovp, orp;
    logic [127:0] pk, px;

    reset = 1'b0;
    iv4 = 1'b0; d4 = 1'b0; or4 = 1'b0; id4 = '0;
    iv8 = 1'b0; d8 = 1'b0; or8 = 1'b0; id8 = '0;
    tick();
    tick();
    chk("rst_out_valid", 128'(ov4), 128'(0));
    chk("rst_in_ready", 128'(ir4), 128'(1));
    chk("rst_busy", 128'(busy4), 128'(0));
    chk("rst_out_data", 128'(od4), 128'(0));
    chk("rst8_out_data", 128'(od8), 128'(0));
    reset = 1'b1;
    tick();

    run4("asc", p4(200, 3, 77, 3), 1'b0, p4(3, 3, 77, 200),
         {2'd0, 2'd2, 2'd3, 2'd1}, 0);
    run4("desc", p4(200, 3, 77, 3), 1'b1, p4(200, 77, 3, 3),
         {2'd3, 2'd1, 2'd2, 2'd0}, 0);
    run4("sorted", p4(1, 2, 3, 4), 1'b0, p4(1, 2, 3, 4),
         {2'd3, 2'd2, 2'd1, 2'd0}, 0);
    run4("bp", p4(5, 250, 0, 128), 1'b0, p4(0, 5, 128, 250),
         {2'd1, 2'd3, 2'd0, 2'd2}, 5);

    iv4 = 1'b1; id4 = p4(5, 1, 4, 2); d4 = 1'b0;
    tick();
    iv4 = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("midrst_out_valid", 128'(ov4), 128'(0));
    chk("midrst_in_ready", 128'(ir4), 128'(1));
    chk("midrst_busy", 128'(busy4), 128'(0));
    reset = 1'b1;
    run4("after_rst", p4(9, 8, 7, 6), 1'b0, p4(6, 7, 8, 9),
         {2'd0, 2'd1, 2'd2, 2'd3}, 0);
    run4("ties", p4(50, 10, 50, 0), 1'b0, p4(0, 10, 50, 50),
         {2'd2, 2'd0, 2'd1, 2'd3}, 0);

    for (int v = 0; v < 200; v++) begin
      k = 0;
      while (!ir8 && k < 50) begin
        tick();
        k++;
      end
      chk("r_in_ready", 128'(ir8), 128'(1));
      for (int i = 0; i < 8; i++) begin
        kk[i] = int'($urandom % 4096);
        id8[i*12 +: 12] = 12'(kk[i]);
      end
      dd = 1'($urandom % 2);
      model(8, 12, 3, kk, dd, pk, px);
      iv8 = 1'b1; d8 = dd;
      tick();
      iv8 = 1'b0;
      cyc = 0; hs = 1'b0; seen = 1'b0; ovp = 1'b0; orp = 1'b0;
      while (!hs && cyc < 60) begin
        tick();
        cyc++;
        if (ovp && orp) begin
          hs = 1'b1;
        end else begin
          if (ov8 && !seen) begin
            seen = 1'b1;
            chk("r_latency", 128'(cyc), 128'(8));
            chk("r_data", 128'(od8), pk);
`ifdef SORT_NET_INDEX_EN
            chk("r_idx", 128'(ox8), px);
`endif
          end
          ovp = ov8;
          or8 = 1'($urandom % 2);
          orp = or8;
          iv8 = 1'($urandom % 2);
          id8 = {$urandom, $urandom, $urandom};
          d8  = 1'($urandom % 2);
        end
      end
      iv8 = 1'b0;
      or8 = 1'b0;
      chk("r_handshake", 128'(hs), 128'(1));
      chk("r_seen", 128'(seen), 128'(1));
      chk("r_no_extra", 128'(ov8), 128'(0));
      chk("r_idle", 128'(ir8), 128'(1));
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
